fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the ID-stage decode controller.
- Owns the PC register, next-PC selection and the IF/ID pipeline register.
- Feeds ID with the instruction, its PC and PC+4, and the Kernel bit that gates interrupts/exceptions in decode.
- Consumes the decoder's PCSource, the hazard unit's Stall and EX's branch resolution.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset (kernel mode).
- IRQ_VEC, 32'h8000_0004, interrupt handler entry.
- EXC_VEC, 32'h8000_0008, undefined-instruction handler entry.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- Stall  input  1  load-use hazard from hazard unit; hold PC and IF/ID.
- BranchTaken  input  1  EX-stage branch resolved taken.
- BranchTarget  input  32  EX-stage branch target.
- PCSource  input  3  from ID decode: 0 seq, 1 j/jal, 2 jr/jalr, 3 IRQ, 4 exception.
- JumpTarget  input  32  ID-computed {PC4[31:28], imm26, 2'b00}.
- JrTarget  input  32  ID-stage forwarded rs value.
- Instruction  input  32  IMem read data for address PC (combinational read).
- PC  output  32  current fetch address to IMem.
- IF_ID_Instruction  output  32  instruction in ID.
- IF_ID_PC  output  32  PC of the ID instruction.
- IF_ID_PC4  output  32  IF_ID_PC + 4.
- IF_ID_Valid  output  1  0 = bubble.
- Kernel  output  1  IF_ID_PC[31].
- FlushIDEX  output  1  combinational; bubble request to the ID/EX register.

Behaviour:
- Reset (reset==0 at edge):
  - PC=RESET_PC.
  - IF_ID_Instruction=0, IF_ID_PC=RESET_PC, IF_ID_PC4=RESET_PC+4, IF_ID_Valid=0.
  - Kernel=1; FlushIDEX follows its inputs combinationally.
  - Reset mid-operation discards all in-flight state, including pending redirects.
- Next PC, highest priority first:
  1. BranchTaken -> BranchTarget.
  2. Stall -> hold PC.
  3. PCSource 3 -> IRQ_VEC; PCSource 4 -> EXC_VEC.
  4. PCSource 1 -> JumpTarget; PCSource 2 -> JrTarget.
  5. Otherwise PC+4.
  - PCSource values 5-7 are treated as 0.
- IF/ID update, same priority:
  - Redirect (BranchTaken, or PCSource 1-4 without Stall) -> flush: IF_ID_Instruction=0, IF_ID_Valid=0, IF_ID_PC=new PC, IF_ID_PC4=new PC+4.
    - The bubble therefore carries the destination's Kernel bit, so a held IRQ cannot re-trigger on the bubble after a vector redirect.
  - Stall only -> hold all IF/ID fields.
  - Otherwise -> load Instruction, PC, PC+4, Valid=1.
- BranchTaken together with Stall: branch wins, because the ID instruction is wrong-path.
- Stall together with PCSource 1-4: the redirect is suppressed; it re-asserts when decode re-evaluates the held instruction.
- FlushIDEX = BranchTaken, combinational. It kills the wrong-path ID instruction entering EX.
- Latencies:
  - Jump/jr/IRQ/exception redirect costs 1 bubble.
  - Taken branch costs 2 bubbles (IF/ID flush plus FlushIDEX).
- Arithmetic: PC+4 is 32-bit, modulo 2^32. 32'hFFFF_FFFC wraps to 0, clearing Kernel; no trap.
- Return-address convention: the decoder writes IF_ID_PC4 to $26 on IntExc, so the handler returns to PC4-4 for IRQ replay. No extra state is kept here.
- PC[1:0] is not checked; misaligned targets pass through unchanged.

Decomposition:
- Shared package constants: RESET_PC, IRQ_VEC, EXC_VEC; PCSource encodings PCSRC_SEQ=0, PCSRC_J=1, PCSRC_JR=2, PCSRC_IRQ=3, PCSRC_EXC=4; NOP=32'h0.
  - Controller and fetch_stage both use these.
- One natural sub-module, if_id_reg: the IF/ID register with hold/flush/load controls and flush payload.
- PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset: hold reset=0 2 cycles, release -> PC=8000_0000, then 8000_0004, 8000_0008. IF_ID_Valid=0 then 1; IF_ID_PC=8000_0000 on the first valid cycle.
- Jump: PCSource=1, JumpTarget=0000_0040 for 1 cycle -> next PC=0000_0040; IF/ID bubble with IF_ID_PC=0000_0040, Kernel=0; fetch resumes at 0000_0044.
- Stall: Stall=1 for 2 cycles at PC=0000_0010 -> PC and IF/ID unchanged both cycles. Stall=1 with PCSource=2 -> no redirect.
- Branch over stall: BranchTaken=1, BranchTarget=0000_0100, Stall=1, PCSource=1 -> PC=0000_0100, FlushIDEX=1, IF/ID bubble.
- IRQ: PCSource=3 at PC=0000_0200 -> PC=8000_0004; bubble with Kernel=1 while IRQ stays high; next cycle sequential 8000_0008.
- Exception and wrap: PCSource=4 -> PC=8000_0008. Separately, sequential fetch from FFFF_FFFC -> PC=0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and the ID decode controller:
// reset/vector addresses, PCSource encodings and small PC helpers.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [2:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_J   = 3'd1,
        PCSRC_JR  = 3'd2,
        PCSRC_IRQ = 3'd3,
        PCSRC_EXC = 3'd4
    } pcsrc_e;

    // Sequential successor; wraps modulo 2^32 with no trap.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // True for the decode-driven redirects (jump, jr, IRQ, exception).
    // Encodings 5-7 are not redirects and behave as sequential fetch.
    function automatic logic is_redirect_src(input logic [2:0] src);
        return (src >= 3'(PCSRC_J)) && (src <= 3'(PCSRC_EXC));
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble that carries the
// redirect destination PC, so the bubble already reflects the Kernel
// bit of the new code stream. Hold freezes every field.
module fetch_stage_if_id_reg #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid
);
    import fetch_stage_pkg::*;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Flush beats hold beats load; the caller never asserts hold during a branch.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_instr <= NOP;
            r_pc    <= RESET_PC;
            r_pc4   <= pc_plus4(RESET_PC);
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP;
            r_pc    <= i_flush_pc;
            r_pc4   <= pc_plus4(i_flush_pc);
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= pc_plus4(i_pc);
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// register. A taken EX branch overrides everything (the ID instruction is
// wrong-path); a stall suppresses decode redirects until decode re-evaluates.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] IRQ_VEC  = fetch_stage_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = fetch_stage_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [2:0]  PCSource,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JrTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        Kernel,
    output logic        FlushIDEX
);
    import fetch_stage_pkg::*;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_seq;
    logic        w_src_redirect;
    logic        w_flush;
    logic        w_hold;

    assign w_pc_seq       = pc_plus4(r_pc);
    assign w_src_redirect = is_redirect_src(PCSource) && !Stall;
    assign w_flush        = BranchTaken || w_src_redirect;
    assign w_hold         = Stall && !BranchTaken;

    // Next-PC priority: branch, stall hold, vectors, jumps, sequential.
    always_comb begin
        w_pc_next = w_pc_seq;
        if (BranchTaken) begin
            w_pc_next = BranchTarget;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end else begin
            case (PCSource)
                PCSRC_IRQ: w_pc_next = IRQ_VEC;
                PCSRC_EXC: w_pc_next = EXC_VEC;
                PCSRC_J:   w_pc_next = JumpTarget;
                PCSRC_JR:  w_pc_next = JrTarget;
                default:   w_pc_next = w_pc_seq;
            endcase
        end
    end

    // PC register; reset drops any redirect that was in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    fetch_stage_if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_hold     (w_hold),
        .i_flush    (w_flush),
        .i_flush_pc (w_pc_next),
        .i_instr    (Instruction),
        .i_pc       (r_pc),
        .o_instr    (IF_ID_Instruction),
        .o_pc       (IF_ID_PC),
        .o_pc4      (IF_ID_PC4),
        .o_valid    (IF_ID_Valid)
    );

    assign PC        = r_pc;
    assign Kernel    = IF_ID_PC[31];
    assign FlushIDEX = BranchTaken;

endmodule
